// File: rtl/spike_rec_pkg.sv
// rtl/spike_rec_pkg.sv - shared widths, defaults and record word type for the spike output recorder
package spike_rec_pkg;

    localparam int NUM_COLS_DEF   = 2;
    localparam int TS_WIDTH_DEF   = 16;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int DROP_W         = 16;

    // Column index width; a single column still needs one bit.
    function automatic int col_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_W = col_w(NUM_COLS_DEF);

    typedef struct packed {
        logic [COL_W-1:0]        col;
        logic [TS_WIDTH_DEF-1:0] ts;
    } rec_word_t;

endpackage

// File: rtl/spike_rec_fifo.sv
// rtl/spike_rec_fifo.sv - show-ahead FIFO with registered head word, push/pop/full/empty/level
module spike_rec_fifo #(
    parameter  int WIDTH = 17,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [LW-1:0]    count;
    logic [LW-1:0]    count_next;
    logic [WIDTH-1:0] head_next;
    logic             do_push;
    logic             do_pop;

    // Full is the registered occupancy, so a same-cycle pop never makes room for a push.
    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head register holds whatever will sit at the read pointer after this edge.
    always_comb begin
        rd_next    = rd_ptr + AW'(do_pop);
        count_next = count + LW'(do_push) - LW'(do_pop);
        head_next  = dout;
        if (count_next != '0) begin
            if (count == LW'(do_pop)) begin
                head_next = din;
            end else begin
                head_next = mem[rd_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_next;
            count  <= count_next;
            dout   <= head_next;
        end
    end

endmodule

// File: rtl/spike_out_recorder.sv
// rtl/spike_out_recorder.sv - timestamps column spikes and queues {col, ts} words; SPIKE_REC_DROP_CNT_EN enables drop counting
module spike_out_recorder
    import spike_rec_pkg::*;
#(
    parameter  int NUM_COLS   = NUM_COLS_DEF,
    parameter  int TS_WIDTH   = TS_WIDTH_DEF,
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int CW         = col_w(NUM_COLS),
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_COLS-1:0]    spike_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CW+TS_WIDTH-1:0] out_data,
    output logic [LW-1:0]          fifo_level,
    output logic [DROP_W-1:0]      drop_count
);

    logic [TS_WIDTH-1:0]    ts;
    logic [TS_WIDTH-1:0]    ts_cap [NUM_COLS];
    logic [NUM_COLS-1:0]    pending;
    logic [NUM_COLS-1:0]    grant;
    logic [NUM_COLS-1:0]    capture;
    logic [CW-1:0]          last_grant;
    logic [CW-1:0]          grant_idx;
    logic                   found;
    logic                   push;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW+TS_WIDTH-1:0] push_word;

    // Round-robin search starting one past the last granted column.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = last_grant;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_COLS; i++) begin
            idx = (int'(last_grant) + 1 + i) % NUM_COLS;
            if (!found && pending[idx]) begin
                found     = 1'b1;
                grant_idx = CW'(idx);
            end
        end
        push = found && !fifo_full;
        if (push) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign push_word = {grant_idx, ts_cap[grant_idx]};

    // A column being granted this cycle may re-arm immediately with the new timestamp.
    assign capture = spike_in & {NUM_COLS{enable}} & (~pending | grant);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts         <= '0;
            pending    <= '0;
            last_grant <= '0;
            for (int c = 0; c < NUM_COLS; c++) begin
                ts_cap[c] <= '0;
            end
        end else begin
            if (enable) begin
                ts <= ts + 1'b1;
            end
            pending <= (pending & ~grant) | capture;
            for (int c = 0; c < NUM_COLS; c++) begin
                if (capture[c]) begin
                    ts_cap[c] <= ts;
                end
            end
            if (push) begin
                last_grant <= grant_idx;
            end
        end
    end

    spike_rec_fifo #(
        .WIDTH (CW + TS_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_word),
        .pop   (out_ready),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign out_valid = !fifo_empty;

`ifdef SPIKE_REC_DROP_CNT_EN
    logic [NUM_COLS-1:0] drop;
    logic [DROP_W:0]     drop_sum;
    logic [DROP_W-1:0]   drop_cnt;

    assign drop     = spike_in & {NUM_COLS{enable}} & pending & ~grant;
    assign drop_sum = {1'b0, drop_cnt} + (DROP_W+1)'($countones(drop));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (drop_sum[DROP_W]) begin
            drop_cnt <= '1;
        end else begin
            drop_cnt <= drop_sum[DROP_W-1:0];
        end
    end

    assign drop_count = drop_cnt;
`else
    assign drop_count = '0;
`endif

endmodule
